// File: rtl/snake_pkg.sv
// Shared types and board constants for the two-snake round referee.
package snake_pkg;

    localparam int GRID_W_C = 40;
    localparam int GRID_H_C = 30;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_S1    = 2'd1,
        CELL_S2    = 2'd2,
        CELL_WALL  = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RD1   = 3'd2,
        RD2   = 3'd3,
        EVAL  = 3'd4,
        DONE  = 3'd5
    } ref_state_t;

    typedef logic [5:0] coord_x_t;
    typedef logic [4:0] coord_y_t;

endpackage

// File: rtl/snake_referee_grid_addr.sv
// Combinational cell index (y*40 + x) plus in-bounds flag; out-of-bounds cells map to index 0.
module grid_addr
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_C,
    parameter int GRID_H = GRID_H_C
) (
    input  logic [5:0]  x,
    input  logic [4:0]  y,
    output logic [10:0] addr,
    output logic        in_bounds
);

    localparam logic [6:0] W_LIM = 7'(GRID_W);
    localparam logic [5:0] H_LIM = 6'(GRID_H);

    always_comb begin
        in_bounds = ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
        addr      = '0;
        if (in_bounds) begin
            // y*40 as (y<<5)+(y<<3) avoids a multiplier
            addr = {1'b0, y, 5'b0} + {3'b0, y, 3'b0} + {5'b0, x};
        end
    end

endmodule

// File: rtl/snake_referee.sv
// Round referee: reads both head cells from the occupancy RAM on each post-grace tick and latches the outcome.
// Latency: evaluating tick at T gives outcome at T+4; ticks while busy, idle or done are dropped.
module snake_referee
    import snake_pkg::*;
#(
    parameter int GRID_W      = GRID_W_C,
    parameter int GRID_H      = GRID_H_C,
    parameter int GRACE_TICKS = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LD_Map1,
    input  logic        tick,
    input  logic [5:0]  head1_x,
    input  logic [4:0]  head1_y,
    input  logic [5:0]  head2_x,
    input  logic [4:0]  head2_y,
    output logic        occ_rd,
    output logic [10:0] occ_addr,
    input  logic [1:0]  occ_data,
    output logic        player1wins,
    output logic        player2wins,
    output logic        tie,
    output logic        busy
);

    ref_state_t state_q, state_d;
    logic [7:0] grace_q, grace_d;
    coord_x_t   h1x_q, h1x_d, h2x_q, h2x_d;
    coord_y_t   h1y_q, h1y_d, h2y_q, h2y_d;
    cell_t      c1_q, c1_d;
    logic       p1_q, p1_d, p2_q, p2_d, tie_q, tie_d;

    logic [10:0] addr1, addr2;
    logic        inb1, inb2;
    logic        same_cell, dead1, dead2;

    grid_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_addr1 (
        .x(h1x_q), .y(h1y_q), .addr(addr1), .in_bounds(inb1)
    );

    grid_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_addr2 (
        .x(h2x_q), .y(h2y_q), .addr(addr2), .in_bounds(inb2)
    );

    // c1 comes from the flop, c2 is the read returning during EVAL
    always_comb begin
        same_cell = (h1x_q == h2x_q) && (h1y_q == h2y_q);
        dead1     = !inb1 || (c1_q != CELL_EMPTY) || same_cell;
        dead2     = !inb2 || (cell_t'(occ_data) != CELL_EMPTY) || same_cell;
    end

    always_comb begin
        state_d = state_q;
        grace_d = grace_q;
        h1x_d   = h1x_q;
        h1y_d   = h1y_q;
        h2x_d   = h2x_q;
        h2y_d   = h2y_q;
        c1_d    = c1_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        tie_d   = tie_q;

        if (!LD_Map1) begin
            state_d = IDLE;
            grace_d = '0;
            p1_d    = 1'b0;
            p2_d    = 1'b0;
            tie_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    grace_d = 8'(GRACE_TICKS);
                end
                ARMED: begin
                    if (tick) begin
                        if (grace_q != '0) begin
                            grace_d = grace_q - 8'd1;
                        end else begin
                            h1x_d   = head1_x;
                            h1y_d   = head1_y;
                            h2x_d   = head2_x;
                            h2y_d   = head2_y;
                            state_d = RD1;
                        end
                    end
                end
                RD1: state_d = RD2;
                RD2: begin
                    c1_d    = cell_t'(occ_data);
                    state_d = EVAL;
                end
                EVAL: begin
                    if (dead1 || dead2) begin
                        state_d = DONE;
                        tie_d   = dead1 && dead2;
                        p2_d    = dead1 && !dead2;
                        p1_d    = dead2 && !dead1;
                    end else begin
                        state_d = ARMED;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            grace_q <= '0;
            h1x_q   <= '0;
            h1y_q   <= '0;
            h2x_q   <= '0;
            h2y_q   <= '0;
            c1_q    <= CELL_EMPTY;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grace_q <= grace_d;
            h1x_q   <= h1x_d;
            h1y_q   <= h1y_d;
            h2x_q   <= h2x_d;
            h2y_q   <= h2y_d;
            c1_q    <= c1_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            tie_q   <= tie_d;
        end
    end

    always_comb begin
        occ_rd   = 1'b0;
        occ_addr = '0;
        busy     = 1'b0;
        case (state_q)
            RD1: begin
                occ_rd   = 1'b1;
                occ_addr = addr1;
                busy     = 1'b1;
            end
            RD2: begin
                occ_rd   = 1'b1;
                occ_addr = addr2;
                busy     = 1'b1;
            end
            EVAL:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign player1wins = p1_q;
    assign player2wins = p2_q;
    assign tie         = tie_q;

endmodule

// File: doc/snake_referee.md
# snake_referee

Round referee for the two-snake game. While the top-level FSM holds the play map active, it evaluates both snake heads on every game tick against the board occupancy RAM and the grid bounds. It drives the `player1wins` / `player2wins` / `tie` level inputs that the top-level FSM consumes to leave the play state. It sits between the snake movement logic, the occupancy RAM read port and the game-state FSM.

## Interface
Parameters:
- `GRID_W`, default 40: board width in cells (640 px / 16 px).
- `GRID_H`, default 30: board height in cells (480 px / 16 px).
- `GRACE_TICKS`, default 2: ticks after round start that are not evaluated.

Ports:
- `Clk`, in, 1: single system clock.
- `Reset`, in, 1: synchronous, active-high.
- `LD_Map1`, in, 1: round active (level from the game FSM).
- `tick`, in, 1: one-cycle game-step pulse. Heads are valid in the same cycle.
- `head1_x`, in, 6: snake 1 head column.
- `head1_y`, in, 5: snake 1 head row.
- `head2_x`, in, 6: snake 2 head column.
- `head2_y`, in, 5: snake 2 head row.
- `occ_rd`, out, 1: occupancy RAM read strobe.
- `occ_addr`, out, 11: cell index = y*GRID_W + x.
- `occ_data`, in, 2: cell contents, valid exactly 1 cycle after `occ_rd`. Encoding: 0 empty, 1 snake-1 body, 2 snake-2 body, 3 wall.
- `player1wins`, out, 1: held level.
- `player2wins`, out, 1: held level.
- `tie`, out, 1: held level.
- `busy`, out, 1: high in RD1/RD2/EVAL.

## Operation
- States:
  - IDLE:
    - When `LD_Map1`=1, go to ARMED and load the grace counter with GRACE_TICKS.
  - ARMED:
    - On `tick` with grace counter > 0: decrement the counter and stay.
    - On `tick` with grace counter = 0: latch both heads and go to RD1.
  - RD1:
    - `occ_rd`=1, `occ_addr`=addr(head1), go to RD2.
  - RD2:
    - `occ_rd`=1, `occ_addr`=addr(head2). Capture `occ_data` as c1. Go to EVAL.
  - EVAL:
    - Use `occ_data` as c2 and decide the outcome.
    - Go to DONE if any snake is dead, else go to ARMED.
  - DONE:
    - Outputs hold. Stay until `LD_Map1`=0.
- Death rules:
  - dead1 = (x1 ≥ GRID_W) | (y1 ≥ GRID_H) | (c1 ≠ 0) | (head1 == head2).
  - dead2 is the same rule for snake 2.
  - When a head is out of bounds, the read is still issued with `occ_addr`=0 and the returned data is ignored.
- Outcome, registered at exit from EVAL:
  - dead1 & dead2: `tie`=1.
  - dead1 only: `player2wins`=1.
  - dead2 only: `player1wins`=1.
  - Exactly one outcome bit is ever high.
- Address arithmetic:
  - y*40 + x computed as (y<<5)+(y<<3)+x, 11-bit, no overflow for in-range coordinates.
- `LD_Map1` falling in any state:
  - Next state IDLE. Outcome bits and grace counter are cleared the next cycle.
  - Any in-flight evaluation is discarded.
- `tick` while `busy` or in DONE/IDLE: ignored, no queuing.

## Timing
- Reset:
  - State IDLE.
  - All outputs 0 (`occ_rd`, `occ_addr`, `player1wins`, `player2wins`, `tie`, `busy`).
  - Grace counter 0.
- Evaluating tick at cycle T:
  - RD1 at T+1.
  - RD2 at T+2.
  - EVAL at T+3.
  - Outcome visible at T+4.
- `occ_rd` is high for exactly 2 consecutive cycles per evaluated tick.
- IDLE→ARMED takes 1 cycle after `LD_Map1` rises. A `tick` in that same cycle is ignored.
- Reset mid-evaluation: IDLE next cycle, everything cleared, no outcome produced.
- Outcome bits stay asserted through DONE. The game FSM consumes them within one cycle.

## Structure
- `snake_pkg` holds:
  - `GRID_W_C`, `GRID_H_C`.
  - `cell_t` enum (CELL_EMPTY, CELL_S1, CELL_S2, CELL_WALL).
  - `ref_state_t` enum (IDLE, ARMED, RD1, RD2, EVAL, DONE).
  - `coord_x_t` (6-bit) and `coord_y_t` (5-bit).
- Sub-module `grid_addr`: combinational x,y → 11-bit index plus an in-bounds flag. Instantiated twice, once per head.

## Test plan
1. Reset, then `LD_Map1`=1. Send 2 ticks with heads (0,0), (39,29). Expect no `occ_rd` and outcomes 0, because of the grace period.
2. After grace, tick with heads (5,5), (10,10) and RAM returning empty. Expect `occ_addr` 205 then 410, back to ARMED, all outcomes 0.
3. Tick with head1 (40,3) and head2 (7,7) empty. Expect `player2wins`=1 at T+4, held until `LD_Map1`=0, then cleared 1 cycle later.
4. Tick with head1 (12,4) reading CELL_S2 and head2 (20,20) reading CELL_WALL. Expect `tie`=1 only.
5. Tick with both heads at (8,8) and RAM empty. Expect `tie`=1.
6. Tick with head2 reading CELL_S2 (self-collision) and head1 empty. Expect `player1wins`=1. Also assert `Reset` during RD2 of a separate run and expect no outcome and IDLE.
